// File: rtl/fp_pkg.sv
// fp_pkg: shared FP types for the issue/writeback path (ops, formats,
// rounding modes, status flags, unit selects and writeback slots).
package fp_pkg;

    typedef enum logic [3:0] {
        NO_FP_OP = 4'd0,
        FADD     = 4'd1,
        FMUL     = 4'd2,
        FMADD    = 4'd3,
        FDIV     = 4'd4,
        I2F      = 4'd5,
        F2I      = 4'd6,
        F2F      = 4'd7,
        FCMP     = 4'd8,
        FCLASS   = 4'd9,
        FMIN     = 4'd10,
        FMAX     = 4'd11,
        FSGNJ    = 4'd12
    } float_op_e;

    typedef enum logic [1:0] {
        FP16 = 2'd0,
        FP32 = 2'd1,
        FP64 = 2'd2
    } fp_format_e;

    typedef enum logic [2:0] {
        RNE = 3'd0,
        RTZ = 3'd1,
        RDN = 3'd2,
        RUP = 3'd3,
        RMM = 3'd4,
        DYN = 3'd7
    } roundmode_e;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } status_t;

    typedef enum logic [2:0] {
        FU_NONE = 3'd0,
        FU_ADD  = 3'd1,
        FU_MUL  = 3'd2,
        FU_FMA  = 3'd3,
        FU_MISC = 3'd4,
        FU_DIV  = 3'd5
    } fu_sel_e;

    typedef struct packed {
        logic    valid;
        fu_sel_e sel;
    } wb_res_t;

    // Undefined encodings map to FU_NONE so the caller can flag them illegal.
    function automatic fu_sel_e op_to_fu(float_op_e op);
        case (op)
            FADD:   return FU_ADD;
            FMUL:   return FU_MUL;
            FMADD:  return FU_FMA;
            FDIV:   return FU_DIV;
            I2F, F2I, F2F, FCMP, FCLASS, FMIN, FMAX, FSGNJ: return FU_MISC;
            default: return FU_NONE;
        endcase
    endfunction

endpackage

// File: rtl/fp_wb_reservation.sv
// fp_wb_reservation: shifting writeback reservation table. Entry 0 is the
// current writeback slot; entries move one step towards 0 every cycle.
module fp_wb_reservation
    import fp_pkg::*;
#(
    parameter int unsigned DEPTH = 5,
    parameter int unsigned IDX_W = 3,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             set_i,
    input  logic [IDX_W-1:0] set_idx_i,
    input  fu_sel_e          set_sel_i,
    input  logic [TAG_W-1:0] set_tag_i,
    input  logic [IDX_W-1:0] query_idx_i,
    output logic             slot_free_o,
    output wb_res_t          head_o,
    output logic [TAG_W-1:0] head_tag_o,
    output logic             any_valid_o
);

    wb_res_t          res_q [DEPTH];
    wb_res_t          res_d [DEPTH];
    logic [TAG_W-1:0] tag_q [DEPTH];
    logic [TAG_W-1:0] tag_d [DEPTH];

    always_comb begin
        for (int unsigned k = 0; k < DEPTH; k++) begin
            res_d[k] = '0;
            tag_d[k] = '0;
        end
        for (int unsigned k = 0; k + 1 < DEPTH; k++) begin
            res_d[k] = res_q[k+1];
            tag_d[k] = tag_q[k+1];
        end
        // The set index is post-shift, so a latency-L op lands in res[L-1].
        if (set_i) begin
            res_d[set_idx_i] = '{valid: 1'b1, sel: set_sel_i};
            tag_d[set_idx_i] = set_tag_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                res_q[k] <= '0;
                tag_q[k] <= '0;
            end
        end else begin
            res_q <= res_d;
            tag_q <= tag_d;
        end
    end

    always_comb begin
        any_valid_o = 1'b0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            any_valid_o = any_valid_o | res_q[k].valid;
        end
    end

    assign slot_free_o = ~res_q[query_idx_i].valid;
    assign head_o      = res_q[0];
    assign head_tag_o  = tag_q[0];

endmodule

// File: rtl/fp_issue_ctrl.sv
// fp_issue_ctrl: issues FP ops to their units, reserves writeback slots and
// muxes writeback/fflags. Define FP_DIV_UNIT_EN to build the divider path.
module fp_issue_ctrl #(
    parameter int unsigned LAT_ADD  = 3,
    parameter int unsigned LAT_MUL  = 3,
    parameter int unsigned LAT_FMA  = 4,
    parameter int unsigned LAT_MISC = 1,
    parameter int unsigned TAG_W    = 5
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [3:0]       in_op_i,
    input  logic [1:0]       in_fmt_i,
    input  logic [2:0]       in_rm_i,
    input  logic [TAG_W-1:0] in_tag_i,
    input  logic [2:0]       frm_i,
    output logic [4:0]       fu_valid_o,
    input  logic             div_ready_i,
    output logic [3:0]       op_o,
    output logic [1:0]       fmt_o,
    output logic [2:0]       rm_o,
    input  logic             div_done_i,
    output logic             div_ack_o,
    input  logic [4:0]       status_i,
    output logic             wb_valid_o,
    output logic [2:0]       wb_sel_o,
    output logic [TAG_W-1:0] wb_tag_o,
    output logic             illegal_o,
    output logic [4:0]       fflags_o,
    input  logic             fflags_clr_i,
    output logic             busy_o
);
    import fp_pkg::*;

    localparam int unsigned MAX_AM = (LAT_ADD > LAT_MUL) ? LAT_ADD : LAT_MUL;
    localparam int unsigned MAX_FM = (LAT_FMA > LAT_MISC) ? LAT_FMA : LAT_MISC;
    localparam int unsigned DEPTH  = ((MAX_AM > MAX_FM) ? MAX_AM : MAX_FM) + 1;
    localparam int unsigned IDX_W  = $clog2(DEPTH);

    float_op_e        op_e;
    fu_sel_e          fu;
    logic             rm_dyn;
    logic [2:0]       rm_res;
    logic             illegal;
    logic             ready;
    logic             hs;
    logic             dispatch;
    logic             res_set;
    logic [IDX_W-1:0] lat;
    logic [IDX_W-1:0] set_idx;
    logic             slot_free;
    wb_res_t          head;
    logic [TAG_W-1:0] head_tag;
    logic             any_valid;
    logic             div_accept;
    logic             div_busy;
    logic             div_ack;
    logic [TAG_W-1:0] div_tag;
    logic [4:0]       fflags_q;
    logic [4:0]       fflags_d;

    fp_wb_reservation #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_res (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .set_i       (res_set),
        .set_idx_i   (set_idx),
        .set_sel_i   (fu),
        .set_tag_i   (in_tag_i),
        .query_idx_i (lat),
        .slot_free_o (slot_free),
        .head_o      (head),
        .head_tag_o  (head_tag),
        .any_valid_o (any_valid)
    );

    always_comb begin
        op_e    = float_op_e'(in_op_i);
        fu      = op_to_fu(op_e);
        rm_dyn  = (in_rm_i == DYN);
        rm_res  = rm_dyn ? frm_i : in_rm_i;
        illegal = (fu == FU_NONE) || (in_fmt_i > FP64) ||
                  (rm_dyn && (frm_i >= 3'd5)) || (in_rm_i inside {3'd5, 3'd6});
`ifndef FP_DIV_UNIT_EN
        if (fu == FU_DIV) illegal = 1'b1;
`endif

        case (fu)
            FU_ADD:  lat = IDX_W'(LAT_ADD);
            FU_MUL:  lat = IDX_W'(LAT_MUL);
            FU_FMA:  lat = IDX_W'(LAT_FMA);
            FU_MISC: lat = IDX_W'(LAT_MISC);
            default: lat = '0;
        endcase
        set_idx = lat - IDX_W'(1);

        // Illegal ops are always taken so they can be flagged and dropped.
        if (!rst_ni)             ready = 1'b0;
        else if (illegal)        ready = 1'b1;
        else if (fu == FU_DIV)   ready = div_accept;
        else                     ready = slot_free;

        hs       = in_valid_i & ready;
        dispatch = hs & ~illegal;
        res_set  = dispatch & (fu != FU_DIV);

        fu_valid_o = '0;
        if (dispatch) begin
            case (fu)
                FU_ADD:  fu_valid_o[0] = 1'b1;
                FU_MUL:  fu_valid_o[1] = 1'b1;
                FU_FMA:  fu_valid_o[2] = 1'b1;
                FU_MISC: fu_valid_o[3] = 1'b1;
                FU_DIV:  fu_valid_o[4] = 1'b1;
                default: fu_valid_o    = '0;
            endcase
        end
    end

`ifdef FP_DIV_UNIT_EN
    logic             div_hs;
    logic             div_busy_q;
    logic             div_busy_d;
    logic [TAG_W-1:0] div_tag_q;
    logic [TAG_W-1:0] div_tag_d;

    assign div_hs     = dispatch & (fu == FU_DIV);
    assign div_accept = div_ready_i & ~div_busy_q;
    // Pipelined results own the writeback port; the divider waits for a gap.
    assign div_ack    = rst_ni & div_done_i & ~head.valid;
    assign div_busy   = div_busy_q;
    assign div_tag    = div_tag_q;

    always_comb begin
        div_busy_d = div_busy_q;
        div_tag_d  = div_tag_q;
        if (div_ack) div_busy_d = 1'b0;
        if (div_hs) begin
            div_busy_d = 1'b1;
            div_tag_d  = in_tag_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            div_busy_q <= 1'b0;
            div_tag_q  <= '0;
        end else begin
            div_busy_q <= div_busy_d;
            div_tag_q  <= div_tag_d;
        end
    end
`else
    logic unused_div_inputs;
    assign unused_div_inputs = div_ready_i | div_done_i;
    assign div_accept = 1'b0;
    assign div_ack    = 1'b0;
    assign div_busy   = 1'b0;
    assign div_tag    = '0;
`endif

    always_comb begin
        wb_valid_o = 1'b0;
        wb_sel_o   = FU_NONE;
        wb_tag_o   = '0;
        if (rst_ni) begin
            if (head.valid) begin
                wb_valid_o = 1'b1;
                wb_sel_o   = head.sel;
                wb_tag_o   = head_tag;
            end else if (div_ack) begin
                wb_valid_o = 1'b1;
                wb_sel_o   = FU_DIV;
                wb_tag_o   = div_tag;
            end
        end
    end

    // A clear in the same cycle as a writeback keeps the incoming flags.
    assign fflags_d = (fflags_clr_i ? 5'b0 : fflags_q) | (wb_valid_o ? status_i : 5'b0);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) fflags_q <= '0;
        else         fflags_q <= fflags_d;
    end

    assign in_ready_o = ready;
    assign illegal_o  = hs & illegal;
    assign op_o       = dispatch ? in_op_i  : 4'b0;
    assign fmt_o      = dispatch ? in_fmt_i : 2'b0;
    assign rm_o       = dispatch ? rm_res   : 3'b0;
    assign div_ack_o  = div_ack;
    assign fflags_o   = fflags_q;
    assign busy_o     = rst_ni & (any_valid | div_busy);

endmodule

// File: tb/tb_fp_issue_ctrl.sv
// Self-checking bench for fp_issue_ctrl: directed vector table plus hand
// sequences for slot collisions, divider arbitration, fflags and reset.
module tb_fp_issue_ctrl;
    import fp_pkg::*;

    logic       clk_i;
    logic       rst_ni;
    logic       in_valid_i;
    logic       in_ready_o;
    logic [3:0] in_op_i;
    logic [1:0] in_fmt_i;
    logic [2:0] in_rm_i;
    logic [4:0] in_tag_i;
    logic [2:0] frm_i;
    logic [4:0] fu_valid_o;
    logic       div_ready_i;
    logic [3:0] op_o;
    logic [1:0] fmt_o;
    logic [2:0] rm_o;
    logic       div_done_i;
    logic       div_ack_o;
    logic [4:0] status_i;
    logic       wb_valid_o;
    logic [2:0] wb_sel_o;
    logic [4:0] wb_tag_o;
    logic       illegal_o;
    logic [4:0] fflags_o;
    logic       fflags_clr_i;
    logic       busy_o;

    int total = 0;
    int bad   = 0;

    fp_issue_ctrl #(
        .LAT_ADD  (3),
        .LAT_MUL  (3),
        .LAT_FMA  (4),
        .LAT_MISC (1),
        .TAG_W    (5)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .in_op_i      (in_op_i),
        .in_fmt_i     (in_fmt_i),
        .in_rm_i      (in_rm_i),
        .in_tag_i     (in_tag_i),
        .frm_i        (frm_i),
        .fu_valid_o   (fu_valid_o),
        .div_ready_i  (div_ready_i),
        .op_o         (op_o),
        .fmt_o        (fmt_o),
        .rm_o         (rm_o),
        .div_done_i   (div_done_i),
        .div_ack_o    (div_ack_o),
        .status_i     (status_i),
        .wb_valid_o   (wb_valid_o),
        .wb_sel_o     (wb_sel_o),
        .wb_tag_o     (wb_tag_o),
        .illegal_o    (illegal_o),
        .fflags_o     (fflags_o),
        .fflags_clr_i (fflags_clr_i),
        .busy_o       (busy_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    typedef struct {
        logic       valid;
        logic [3:0] op;
        logic [1:0] fmt;
        logic [2:0] rm;
        logic [2:0] frm;
        logic [4:0] tag;
        logic       exp_ready;
        logic [4:0] exp_fu;
        logic [2:0] exp_rm;
        logic       exp_ill;
        int         lat;
        logic [2:0] exp_sel;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic v, logic [3:0] op, logic [1:0] fmt, logic [2:0] rm,
                                logic [2:0] frm, logic [4:0] tag, logic rdy, logic [4:0] fu,
                                logic [2:0] erm, logic ill, int lat, logic [2:0] sel);
        vec_t r;
        r.valid = v;   r.op = op;       r.fmt = fmt;     r.rm = rm;
        r.frm = frm;   r.tag = tag;     r.exp_ready = rdy;
        r.exp_fu = fu; r.exp_rm = erm;  r.exp_ill = ill;
        r.lat = lat;   r.exp_sel = sel;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [1:0] fmt,
                         input logic [2:0] rm, input logic [2:0] frm, input logic [4:0] tag);
        @(negedge clk_i);
        in_valid_i = v;
        in_op_i    = op;
        in_fmt_i   = fmt;
        in_rm_i    = rm;
        frm_i      = frm;
        in_tag_i   = tag;
        #2;
    endtask

    task automatic idle();
        drive(1'b0, NO_FP_OP, FP32, RNE, 3'd0, 5'd0);
    endtask

    initial begin
        vecs.push_back(mk(1, FADD,   FP32, RNE,  0, 3,  1, 5'b00001, 3'd0, 0, 3, FU_ADD));
        vecs.push_back(mk(1, FMUL,   FP64, RUP,  0, 7,  1, 5'b00010, 3'd3, 0, 3, FU_MUL));
        vecs.push_back(mk(1, FMADD,  FP16, RMM,  0, 9,  1, 5'b00100, 3'd4, 0, 4, FU_FMA));
        vecs.push_back(mk(1, FCMP,   FP32, RDN,  0, 11, 1, 5'b01000, 3'd2, 0, 1, FU_MISC));
        vecs.push_back(mk(1, FSGNJ,  FP32, DYN,  1, 12, 1, 5'b01000, 3'd1, 0, 1, FU_MISC));
        vecs.push_back(mk(1, FADD,   FP32, DYN,  5, 13, 1, 5'b00000, 3'd0, 1, 0, FU_NONE));
        vecs.push_back(mk(1, FMUL,   FP64, DYN,  7, 14, 1, 5'b00000, 3'd0, 1, 0, FU_NONE));
        vecs.push_back(mk(1, FADD,   FP32, 3'd5, 0, 15, 1, 5'b00000, 3'd0, 1, 0, FU_NONE));
        vecs.push_back(mk(1, FMUL,   FP32, 3'd6, 0, 16, 1, 5'b00000, 3'd0, 1, 0, FU_NONE));
        vecs.push_back(mk(1, FADD,   2'd3, RNE,  0, 17, 1, 5'b00000, 3'd0, 1, 0, FU_NONE));
        vecs.push_back(mk(1, NO_FP_OP, FP32, RNE, 0, 18, 1, 5'b00000, 3'd0, 1, 0, FU_NONE));
        vecs.push_back(mk(1, 4'd14,  FP32, RNE,  0, 19, 1, 5'b00000, 3'd0, 1, 0, FU_NONE));
        vecs.push_back(mk(0, FADD,   FP32, RNE,  0, 20, 1, 5'b00000, 3'd0, 0, 0, FU_NONE));
        vecs.push_back(mk(1, F2I,    FP64, RTZ,  7, 21, 1, 5'b01000, 3'd1, 0, 1, FU_MISC));
        vecs.push_back(mk(1, I2F,    FP16, DYN,  4, 22, 1, 5'b01000, 3'd4, 0, 1, FU_MISC));

        rst_ni       = 1'b0;
        in_valid_i   = 1'b1;
        in_op_i      = FADD;
        in_fmt_i     = FP32;
        in_rm_i      = RNE;
        in_tag_i     = 5'd1;
        frm_i        = 3'd0;
        div_ready_i  = 1'b1;
        div_done_i   = 1'b1;
        status_i     = 5'b11111;
        fflags_clr_i = 1'b0;

        // Reset state: all outputs held at zero even with live inputs.
        repeat (2) @(posedge clk_i);
        @(negedge clk_i); #2;
        chk("rst_ready",   32'(in_ready_o), 32'd0);
        chk("rst_fu",      32'(fu_valid_o), 32'd0);
        chk("rst_wb",      32'(wb_valid_o), 32'd0);
        chk("rst_busy",    32'(busy_o),     32'd0);
        chk("rst_fflags",  32'(fflags_o),   32'd0);
        chk("rst_illegal", 32'(illegal_o),  32'd0);
        chk("rst_divack",  32'(div_ack_o),  32'd0);
        chk("rst_op",      32'(op_o),       32'd0);

        @(negedge clk_i);
        rst_ni     = 1'b1;
        in_valid_i = 1'b0;
        div_done_i = 1'b0;
        status_i   = 5'b0;
        #2;
        chk("post_rst_fflags", 32'(fflags_o), 32'd0);
        chk("post_rst_busy",   32'(busy_o),   32'd0);

        // Vector table: one op from an idle table, then drain and watch writeback.
        for (int i = 0; i < vecs.size(); i++) begin
            vec_t v;
            v = vecs[i];
            drive(v.valid, v.op, v.fmt, v.rm, v.frm, v.tag);
            chk($sformatf("v%0d_ready", i),   32'(in_ready_o), 32'(v.exp_ready));
            chk($sformatf("v%0d_fu", i),      32'(fu_valid_o), 32'(v.exp_fu));
            chk($sformatf("v%0d_illegal", i), 32'(illegal_o),  32'(v.exp_ill));
            chk($sformatf("v%0d_rm", i),      32'(rm_o),       32'(v.exp_rm));
            chk($sformatf("v%0d_op", i),      32'(op_o),  (v.exp_fu != 0) ? 32'(v.op)  : 32'd0);
            chk($sformatf("v%0d_fmt", i),     32'(fmt_o), (v.exp_fu != 0) ? 32'(v.fmt) : 32'd0);
            for (int k = 1; k <= 6; k++) begin
                idle();
                if (k == 1) begin
                    chk($sformatf("v%0d_illegal_drop", i), 32'(illegal_o), 32'd0);
                end
                chk($sformatf("v%0d_wb_c%0d", i, k), 32'(wb_valid_o), (k == v.lat) ? 32'd1 : 32'd0);
                if (k == v.lat) begin
                    chk($sformatf("v%0d_wb_sel", i), 32'(wb_sel_o), 32'(v.exp_sel));
                    chk($sformatf("v%0d_wb_tag", i), 32'(wb_tag_o), 32'(v.tag));
                end
            end
            chk($sformatf("v%0d_idle_busy", i), 32'(busy_o), 32'd0);
        end

        // FMADD then FMUL on the next cycle would share a writeback slot.
        drive(1, FMADD, FP32, RNE, 0, 5'd4);
        chk("col_fma_fu", 32'(fu_valid_o), 32'b00100);
        drive(1, FMUL, FP32, RNE, 0, 5'd5);
        chk("col_mul_stall", 32'(in_ready_o), 32'd0);
        chk("col_mul_nofu",  32'(fu_valid_o), 32'd0);
        drive(1, FMUL, FP32, RNE, 0, 5'd5);
        chk("col_mul_ready", 32'(in_ready_o), 32'd1);
        chk("col_mul_fu",    32'(fu_valid_o), 32'b00010);
        idle();
        chk("col_t3_wb",   32'(wb_valid_o), 32'd0);
        chk("col_t3_busy", 32'(busy_o),     32'd1);
        idle();
        chk("col_fma_wb",  32'(wb_valid_o), 32'd1);
        chk("col_fma_sel", 32'(wb_sel_o),   32'(FU_FMA));
        chk("col_fma_tag", 32'(wb_tag_o),   32'd4);
        idle();
        chk("col_mul_wb",  32'(wb_valid_o), 32'd1);
        chk("col_mul_sel", 32'(wb_sel_o),   32'(FU_MUL));
        chk("col_mul_tag", 32'(wb_tag_o),   32'd5);
        idle();
        chk("col_done_wb",   32'(wb_valid_o), 32'd0);
        chk("col_done_busy", 32'(busy_o),     32'd0);

        // fflags: accumulate, clear-with-writeback, plain clear, status without writeback.
        drive(1, FCMP, FP32, RNE, 0, 5'd1);
        idle();
        status_i = 5'b10000;
        drive(1, FCMP, FP32, RNE, 0, 5'd2);
        status_i = 5'b00000;
        chk("ff_nv", 32'(fflags_o), 32'b10000);
        idle();
        status_i = 5'b00001;
        drive(1, FCMP, FP32, RNE, 0, 5'd3);
        status_i = 5'b00000;
        chk("ff_acc", 32'(fflags_o), 32'b10001);
        idle();
        chk("ff_clr_wb_valid", 32'(wb_valid_o), 32'd1);
        status_i     = 5'b00001;
        fflags_clr_i = 1'b1;
        idle();
        status_i     = 5'b00000;
        fflags_clr_i = 1'b0;
        chk("ff_clr_keep_new", 32'(fflags_o), 32'b00001);
        fflags_clr_i = 1'b1;
        idle();
        fflags_clr_i = 1'b0;
        chk("ff_clr_only", 32'(fflags_o), 32'b00000);
        status_i = 5'b11111;
        idle();
        status_i = 5'b00000;
        chk("ff_no_wb", 32'(fflags_o), 32'b00000);

`ifdef FP_DIV_UNIT_EN
        // Divider waits for a free writeback cycle behind a MISC result.
        drive(1, FDIV, FP64, RTZ, 0, 5'd20);
        chk("div_ready", 32'(in_ready_o), 32'd1);
        chk("div_fu",    32'(fu_valid_o), 32'b10000);
        chk("div_rm",    32'(rm_o),       32'd1);
        drive(1, FCMP, FP32, RNE, 0, 5'd22);
        chk("div_misc_fu", 32'(fu_valid_o), 32'b01000);
        chk("div_busy",    32'(busy_o),     32'd1);
        drive(1, FDIV, FP32, RNE, 0, 5'd23);
        chk("div_second_stall", 32'(in_ready_o), 32'd0);
        div_done_i = 1'b1;
        #1;
        chk("div_ack_blocked", 32'(div_ack_o), 32'd0);
        chk("div_misc_wb",     32'(wb_valid_o), 32'd1);
        chk("div_misc_sel",    32'(wb_sel_o),   32'(FU_MISC));
        chk("div_misc_tag",    32'(wb_tag_o),   32'd22);
        idle();
        chk("div_ack",    32'(div_ack_o),  32'd1);
        chk("div_wb",     32'(wb_valid_o), 32'd1);
        chk("div_wb_sel", 32'(wb_sel_o),   32'(FU_DIV));
        chk("div_wb_tag", 32'(wb_tag_o),   32'd20);
        idle();
        div_done_i = 1'b0;
        #1;
        chk("div_idle_busy", 32'(busy_o),    32'd0);
        chk("div_idle_ack",  32'(div_ack_o), 32'd0);
`else
        drive(1, FDIV, FP32, RNE, 0, 5'd20);
        chk("nodiv_illegal", 32'(illegal_o),  32'd1);
        chk("nodiv_ready",   32'(in_ready_o), 32'd1);
        chk("nodiv_fu",      32'(fu_valid_o), 32'd0);
        idle();
        chk("nodiv_pulse", 32'(illegal_o), 32'd0);
        chk("nodiv_busy",  32'(busy_o),    32'd0);
`endif

        // Reset with three reservations (and a divide when built) in flight.
`ifdef FP_DIV_UNIT_EN
        drive(1, FDIV, FP32, RNE, 0, 5'd21);
        chk("rf_div_fu", 32'(fu_valid_o), 32'b10000);
`endif
        drive(1, FADD, FP32, RNE, 0, 5'd1);
        chk("rf_add1", 32'(fu_valid_o), 32'b00001);
        drive(1, FADD, FP32, RNE, 0, 5'd2);
        chk("rf_add2", 32'(fu_valid_o), 32'b00001);
        drive(1, FADD, FP32, RNE, 0, 5'd3);
        chk("rf_add3", 32'(fu_valid_o), 32'b00001);
        chk("rf_busy_before", 32'(busy_o), 32'd1);
        @(negedge clk_i);
        rst_ni     = 1'b0;
        in_valid_i = 1'b0;
        #2;
        chk("rf_wb_in_rst", 32'(wb_valid_o), 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        #2;
        chk("rf_busy_after", 32'(busy_o), 32'd0);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("rf_no_wb_%0d", k), 32'(wb_valid_o), 32'd0);
            idle();
        end
        chk("rf_busy_end", 32'(busy_o), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
